// File: rtl/node_tx_queue_if.sv
// Node-side injection queue bus: node strobe path in, core offer/ack path out.
// The queue itself uses the slave modport; the node/core side uses master.
interface node_tx_queue_if #(
   parameter int DEPTH = 4,
   parameter int PKT_W = 29
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [PKT_W-1:0] Node_Pkt;
   logic             Node_Pkt_Strobe;
   logic             Node_Pkt_Full;
   logic             Core_Load_Ack;
   logic [PKT_W-1:0] Packet_From_Node;
   logic             Packet_From_Node_Valid;
   logic [CW-1:0]    Queue_Count;
   logic [7:0]       Drop_Count;

   modport slave (
      input  Node_Pkt, Node_Pkt_Strobe, Core_Load_Ack,
      output Node_Pkt_Full, Packet_From_Node, Packet_From_Node_Valid,
             Queue_Count, Drop_Count
   );

   modport master (
      output Node_Pkt, Node_Pkt_Strobe, Core_Load_Ack,
      input  Node_Pkt_Full, Packet_From_Node, Packet_From_Node_Valid,
             Queue_Count, Drop_Count
   );
endinterface

// File: rtl/node_tx_queue.sv
// Node injection FIFO with IDLE/OFFER/GAP offer FSM toward the router core load port.
// Optional saturating drop counter enabled by defining NODE_TXQ_DROP_CNT_EN.
module node_tx_queue #(
   parameter int DEPTH = 4,
   parameter int PKT_W = 29
) (
   input logic Clk_R,
   input logic Rst_n,
   node_tx_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [PKT_W-1:0] mem_q [DEPTH];
   logic [PKT_W-1:0] mem_d [DEPTH];

   logic full;
   logic push;
   logic pop;

   // Full is judged on the registered count, so a same-cycle pop never rescues a strobe.
   assign full = (count_q == CW'(DEPTH));
   assign push = bus.Node_Pkt_Strobe && !full;
   assign pop  = (state_q == OFFER) && bus.Core_Load_Ack;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = (push && (wr_ptr_q == AW'(i))) ? bus.Node_Pkt : mem_q[i];
      end
   end

   // Storage contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge Clk_R) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge Clk_R or negedge Rst_n) begin
      if (!Rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge Clk_R or negedge Rst_n) begin
      if (!Rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // GAP looks at the post-push count so a packet landing during the gap is offered next.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (count_q != '0) state_d = OFFER;
         OFFER:   if (bus.Core_Load_Ack) state_d = GAP;
         GAP:     state_d = (count_d != '0) ? OFFER : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.Packet_From_Node_Valid = (state_q == OFFER);
      bus.Packet_From_Node       = mem_q[rd_ptr_q];
      bus.Node_Pkt_Full          = full;
      bus.Queue_Count            = count_q;
   end

`ifdef NODE_TXQ_DROP_CNT_EN
   logic       drop;
   logic [7:0] drop_cnt_q, drop_cnt_d;

   assign drop = bus.Node_Pkt_Strobe && full;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
   end

   always_ff @(posedge Clk_R or negedge Rst_n) begin
      if (!Rst_n) drop_cnt_q <= 8'd0;
      else        drop_cnt_q <= drop_cnt_d;
   end

   assign bus.Drop_Count = drop_cnt_q;
`else
   assign bus.Drop_Count = 8'd0;
`endif

endmodule

// File: doc/node_tx_queue.md
# node_tx_queue

Node-side injection queue sitting directly upstream of the router core's node load port. It absorbs packet strobes from the local node, which has no backpressure, and buffers them in a small FIFO. It offers the head packet to the router core on `Packet_From_Node`/`Packet_From_Node_Valid` and retires it when the core returns `Core_Load_Ack`. Packets arriving while the queue is full are dropped and flagged.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, 2..16
- `PKT_W`, 29, packet width; matches the core's `Packet_From_Node`
- `Clk_R`  in  1  router clock; single clock domain
- `Rst_n`  in  1  asynchronous, active-low reset
- `Node_Pkt`  in  PKT_W  packet from the node
- `Node_Pkt_Strobe`  in  1  one-cycle strobe; `Node_Pkt` is valid this cycle; no backpressure
- `Node_Pkt_Full`  out  1  advisory; queue full, a strobe now is dropped
- `Core_Load_Ack`  in  1  one-cycle pulse from the core; head packet was consumed
- `Packet_From_Node`  out  PKT_W  head packet offered to the core
- `Packet_From_Node_Valid`  out  1  offer valid
- `Queue_Count`  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- `Drop_Count`  out  8  saturating drop counter (see Configuration)

## Operation
- Storage is a DEPTH×PKT_W register array with `wr_ptr`/`rd_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH. An occupancy counter `count` drives `Queue_Count`.
- `Node_Pkt_Full` = (count == DEPTH). It is combinational from the registered count.
- Push: `Node_Pkt_Strobe` && !full writes `Node_Pkt` at `wr_ptr`, then `wr_ptr`++ and count++.
- Drop: `Node_Pkt_Strobe` && full leaves the storage and pointers unchanged.
- Full is evaluated at the start of the cycle. A strobe while full is dropped even if a pop occurs in the same cycle.
- `Packet_From_Node` = mem[rd_ptr]. It is held stable for the whole offer because `rd_ptr` changes only on pop.
- FSM, all state registered:
  - IDLE: valid=0. Go to OFFER when count>0.
  - OFFER: valid=1. On `Core_Load_Ack`: pop (`rd_ptr`++, count--), then go to GAP.
  - GAP: valid=0 for exactly one cycle. Then go to OFFER if count>0 (count after any push this cycle), else IDLE.
- `Core_Load_Ack` in IDLE or GAP is ignored: no pop and no state change.
- Push and pop in the same cycle leave count unchanged; both pointers advance.
- Reset mid-operation discards all queued packets; no partial offer survives.

## Timing
- Reset values:
  - state=IDLE, pointers=0, count=0
  - `Packet_From_Node_Valid`=0, `Queue_Count`=0, `Node_Pkt_Full`=0, `Drop_Count`=0
  - `Packet_From_Node` = mem[0]; contents after reset are don't-care
- Strobe into an empty queue at edge N makes count=1 after edge N. The FSM enters OFFER at edge N+1, so valid is high from N+1: 1 cycle latency after the push edge.
- Ack sampled at edge M pops the packet. Valid is low during cycle M..M+1 (GAP) and is high again after edge M+1 if the queue is non-empty. Minimum spacing between offers is 2 cycles.
- The full flag deasserts the cycle after the pop edge.

## Configuration
- `NODE_TXQ_DROP_CNT_EN` defined:
  - `Drop_Count` increments on each dropped strobe and saturates at 255.
  - It clears only on reset.
- Undefined:
  - `Drop_Count` is tied to 8'd0 and no counter logic is generated.
  - Drop behaviour itself is unchanged.

## Test plan
- Reset, then strobe 29'h0ABCDEF at edge 1 -> valid=1 after edge 2, `Packet_From_Node`=29'h0ABCDEF, `Queue_Count`=1; ack -> valid=0 for one cycle, then stays 0, count=0.
- Four strobes 1,2,3,4 back-to-back with no ack (DEPTH=4) -> `Node_Pkt_Full`=1, count=4. A fifth strobe 5 -> dropped; `Drop_Count`=1 with the macro, 0 without.
- Drain a full queue with an ack every offer -> outputs 1,2,3,4 in order with a 1-cycle valid gap between each; count ends at 0, pointers wrapped.
- Queue full, strobe and ack in the same cycle -> strobe dropped, count=3, head advances.
- Queue at count=1 in OFFER, strobe and ack in the same cycle -> count stays 1, GAP, then OFFER of the new packet.
- Ack pulses during IDLE and GAP -> no pop, count unchanged. Assert `Rst_n` low mid-OFFER with count=3 -> valid=0 and count=0 immediately (asynchronous).
- With the macro, 300 strobes into a full queue -> `Drop_Count` saturates at 255.
